register_arbiter: RTL

REGISTER_ARBITER -- requirements
Module: register_arbiter

---
 rtl/register_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/register_arbiter.sv
// register_arbiter: round-robin arbiter sharing one register-set port between host and SD core.
// Optional watchdog enabled by defining REG_ARB_TIMEOUT_EN.
module register_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  host_req,
    input  logic        host_wnr,
    input  logic [7:0]  host_address,
    input  logic [31:0] host_data_in,
    output logic        host_ack,
    output logic [31:0] host_data_out,
    input  logic [1:0]  core_req,
    input  logic        core_wnr,
    input  logic [7:0]  core_address,
    input  logic [31:0] core_data_in,
    output logic        core_ack,
    output logic [31:0] core_data_out,
    output logic [1:0]  reg_req,
    output logic        reg_wnr,
    output logic [7:0]  reg_address,
    output logic [31:0] reg_data_in,
    input  logic        reg_ack,
    input  logic [31:0] reg_data_out,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, XFER_HOST, XFER_CORE, RESP} state_t;

    state_t      r_state;
    logic        r_last_core;
    logic [1:0]  r_req;
    logic        r_wnr;
    logic [7:0]  r_address;
    logic [31:0] r_data_in;
    logic [1:0]  r_grant;
    logic        w_host_req;
    logic        w_core_req;
    logic        w_pick_host;
    logic        w_xfer;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata;

    assign w_host_req  = |host_req;
    assign w_core_req  = |core_req;
    // On a tie the requester that did not win last time gets the grant.
    assign w_pick_host = w_host_req & (~w_core_req | r_last_core);
    assign w_xfer      = (r_state == XFER_HOST) || (r_state == XFER_CORE);
    assign w_done      = w_xfer & (reg_ack | w_timeout);
    assign w_rdata     = w_timeout ? 32'hFFFF_FFFF : reg_data_out;

    assign reg_req     = w_xfer ? r_req : 2'b00;
    assign reg_wnr     = r_wnr;
    assign reg_address = r_address;
    assign reg_data_in = r_data_in;
    assign grant       = r_grant;

`ifdef REG_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    // Fires on the edge where the count of ack-less XFER cycles reaches the limit.
    assign w_timeout = w_xfer & ~reg_ack & ((r_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= 8'd0;
        else if (!w_xfer)
            r_cnt <= 8'd0;
        else if (!reg_ack)
            r_cnt <= r_cnt + 8'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_core   <= 1'b1;
            r_req         <= 2'b00;
            r_wnr         <= 1'b0;
            r_address     <= 8'd0;
            r_data_in     <= 32'd0;
            r_grant       <= 2'b00;
            host_ack      <= 1'b0;
            core_ack      <= 1'b0;
            host_data_out <= 32'd0;
            core_data_out <= 32'd0;
            timeout_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_host_req || w_core_req) begin
                        r_state     <= w_pick_host ? XFER_HOST : XFER_CORE;
                        r_grant     <= w_pick_host ? 2'b01 : 2'b10;
                        r_last_core <= ~w_pick_host;
                        r_req       <= w_pick_host ? host_req : core_req;
                        r_wnr       <= w_pick_host ? host_wnr : core_wnr;
                        r_address   <= w_pick_host ? host_address : core_address;
                        r_data_in   <= w_pick_host ? host_data_in : core_data_in;
                    end
                end
                XFER_HOST, XFER_CORE: begin
                    if (w_done) begin
                        r_state     <= RESP;
                        timeout_err <= w_timeout;
                        host_ack    <= (r_state == XFER_HOST);
                        core_ack    <= (r_state == XFER_CORE);
                        // Writes leave the requester's read data untouched unless the watchdog fired.
                        if (w_timeout || !r_wnr) begin
                            if (r_state == XFER_HOST)
                                host_data_out <= w_rdata;
                            else
                                core_data_out <= w_rdata;
                        end
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_grant     <= 2'b00;
                    host_ack    <= 1'b0;
                    core_ack    <= 1'b0;
                    timeout_err <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
